// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU control decoder and its multiply/divide sequencer.
// Holds ALU control codes, R-type funct values, ALUop classes and the sequencer state type.
package alu_ctrl_pkg;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_ADDU = 4'b0011;
    localparam logic [3:0] CTRL_SLL  = 4'b0100;
    localparam logic [3:0] CTRL_SLTU = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SUBU = 4'b1000;
    localparam logic [3:0] CTRL_MDU  = 4'b1001;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;

    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // Low two funct bits of an MDU instruction select the operation directly.
    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } seq_state_t;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

    function automatic logic is_mfhilo_funct(input logic [5:0] f);
        return (f == FUNCT_MFHI) || (f == FUNCT_MFLO);
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// Multiply/divide sequencer: holds busy for the op latency, then pulses hilo_we once.
// Two-process IDLE/BUSY FSM with a down-counter loaded at acceptance.
module mdu_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [1:0] i_op,
    output logic       o_busy,
    output logic [1:0] o_mdu_op,
    output logic       o_hilo_we
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_op;
    logic [1:0]       w_op_nxt;
    logic             r_hilo_we;
    logic             w_hilo_we_nxt;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_op_nxt      = r_op;
        w_hilo_we_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_BUSY;
                    w_op_nxt    = i_op;
                    // Bit 1 clear means MULT/MULTU, set means DIV/DIVU.
                    w_cnt_nxt   = i_op[1] ? DIV_LOAD : MUL_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = S_IDLE;
                    w_hilo_we_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= MDU_MULT;
            r_hilo_we <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_op      <= w_op_nxt;
            r_hilo_we <= w_hilo_we_nxt;
        end
    end

    assign o_busy    = (r_state == S_BUSY);
    assign o_mdu_op  = r_op;
    assign o_hilo_we = r_hilo_we;

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with MDU hazard stall; the multiply/divide timing lives in mdu_seq.
// Control, illegal and stall are combinational; busy, mdu_op and hilo_we are registered.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [1:0]        ALUop,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] Control,
    output logic              illegal,
    output logic              stall,
    output logic              busy,
    output logic [1:0]        mdu_op,
    output logic              hilo_we
);

    logic [3:0] w_code;
    logic       w_undef;
    logic       w_is_mdu;
    logic       w_is_mf;
    logic       w_start;
    logic       w_busy;
    logic       w_hilo_we;
    logic [1:0] w_mdu_op;

    always_comb begin
        w_code  = CTRL_ADD;
        w_undef = 1'b0;
        case (ALUop)
            ALUOP_ADD: w_code = CTRL_ADD;
            ALUOP_SUB: w_code = CTRL_SUB;
            ALUOP_OR:  w_code = CTRL_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:   w_code = CTRL_ADD;
                    FUNCT_ADDU:  w_code = CTRL_ADDU;
                    FUNCT_SUB:   w_code = CTRL_SUB;
                    FUNCT_SUBU:  w_code = CTRL_SUBU;
                    FUNCT_AND:   w_code = CTRL_AND;
                    FUNCT_OR:    w_code = CTRL_OR;
                    FUNCT_NOR:   w_code = CTRL_NOR;
                    FUNCT_SLL:   w_code = CTRL_SLL;
                    FUNCT_SLT:   w_code = CTRL_SLT;
                    FUNCT_SLTU:  w_code = CTRL_SLTU;
                    FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                    FUNCT_MFHI, FUNCT_MFLO:
                                 w_code = CTRL_MDU;
                    default:     w_undef = 1'b1;
                endcase
            end
            default: w_code = CTRL_ADD;
        endcase
    end

    assign Control = w_undef ? {CTRL_W{1'b1}} : CTRL_W'(w_code);
    assign illegal = valid & w_undef;

    // MDU-class funct codes only mean anything on R-type instructions.
    assign w_is_mdu = (ALUop == ALUOP_RTYPE) && is_mdu_funct(funct);
    assign w_is_mf  = (ALUop == ALUOP_RTYPE) && is_mfhilo_funct(funct);

    // Covering the hilo_we cycle keeps a new op from racing the pending HI/LO write.
    assign stall   = valid & (w_is_mdu | w_is_mf) & (w_busy | w_hilo_we);
    assign w_start = valid & w_is_mdu & ~stall;

    mdu_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_op      (funct[1:0]),
        .o_busy    (w_busy),
        .o_mdu_op  (w_mdu_op),
        .o_hilo_we (w_hilo_we)
    );

    assign busy    = w_busy;
    assign mdu_op  = w_mdu_op;
    assign hilo_we = w_hilo_we;

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter CTRL_W, default 4, SHALL set the Control width (minimum 4).
REQ-002 Parameter MUL_LAT, default 4, SHALL set the multiply busy cycles (minimum 1).
REQ-003 Parameter DIV_LAT, default 8, SHALL set the divide busy cycles (minimum 1).
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the synchronous, active-low reset.
REQ-006 valid  in  1  SHALL flag that ALUop/funct carry a live instruction this cycle.
REQ-007 ALUop  in  2  SHALL be the main-decoder ALU operation class.
REQ-008 funct  in  6  SHALL be the R-type function field.
REQ-009 Control  out  CTRL_W  SHALL be the ALU operation code (combinational).
REQ-010 illegal  out  1  SHALL flag an undefined funct while valid and ALUop=10 (combinational).
REQ-011 stall  out  1  SHALL request a pipeline hold of the current instruction (combinational).
REQ-012 busy  out  1  SHALL indicate the multiply/divide sequencer is running (registered).
REQ-013 mdu_op  out  2  SHALL hold the accepted MDU op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (registered).
REQ-014 hilo_we  out  1  SHALL be a one-cycle HI/LO write strobe (registered).

Function
REQ-015 ALUop 00 SHALL give Control ADD (0010); 01 SUB (0110); 11 OR (0001); 10 SHALL decode funct.
REQ-016 funct decode SHALL be: 100000 ADD 0010, 100001 ADDU 0011, 100010 SUB 0110, 100011 SUBU 1000, 100100 AND 0000, 100101 OR 0001, 100111 NOR 1100, 000000 SLL 0100, 101010 SLT 0111, 101011 SLTU 0101.
REQ-017 funct 011000/011001/011010/011011 (MULT/MULTU/DIV/DIVU) and 010000/010010 (MFHI/MFLO) SHALL give Control 1001 (MDU pass) and illegal=0.
REQ-018 Any other funct with ALUop=10 SHALL give Control all-ones and illegal=valid; codes SHALL be zero-extended when CTRL_W>4.
REQ-019 Sequencer states SHALL be IDLE and BUSY only; counter width clog2(max(MUL_LAT,DIV_LAT)+1).
REQ-020 stall SHALL equal valid AND (MDU op OR MFHI/MFLO) AND (busy OR hilo_we).
REQ-021 In IDLE, valid MDU op with stall=0 SHALL be accepted: next edge state=BUSY, mdu_op=funct[1:0], counter=LAT-1 (MUL_LAT for 0110xx with funct[1]=0, DIV_LAT otherwise).
REQ-022 In BUSY, counter SHALL decrement each edge; edge with counter=0 SHALL set IDLE and hilo_we=1 for exactly one cycle.
REQ-023 busy SHALL be high exactly LAT cycles after acceptance; hilo_we SHALL follow in the next cycle.
REQ-024 mdu_op SHALL stay stable from acceptance through the hilo_we cycle.
REQ-025 No MDU op SHALL be accepted during the hilo_we cycle (stalled per REQ-020); acceptance resumes the cycle after.
REQ-026 valid=0 SHALL never start the sequencer nor assert stall or illegal; Control still decodes.
REQ-027 Illegal instructions SHALL not affect sequencer state.

Reset
REQ-028 rst_n=0 at an edge SHALL force IDLE, counter=0, busy=0, hilo_we=0, mdu_op=00.
REQ-029 Reset during BUSY SHALL abort the operation with no hilo_we emitted afterwards.
REQ-030 Reset SHALL take priority over acceptance in the same cycle.

Structure
REQ-031 Shared package alu_ctrl_pkg SHALL hold Control codes, funct constants, ALUop constants and the sequencer state type.
REQ-032 The IDLE/BUSY FSM, counter and hilo_we SHALL live in sub-module mdu_seq; decode stays in alu_ctrl_seq.

Verification
REQ-033 ALUop=10, sweep all ten funct codes of REQ-016, valid=1 -> matching Control, illegal=0, stall=0; funct=111111 -> Control=1111, illegal=1.
REQ-034 ALUop 00/01/11 with funct=101010 -> Control 0010/0110/0001, illegal=0.
REQ-035 Defaults, MULT issued at cycle 0 -> busy cycles 1-4, hilo_we cycle 5 only, mdu_op=00 cycles 1-5.
REQ-036 DIVU accepted then MFLO held valid -> stall=1 cycles 1-9, MFLO proceeds cycle 10, mdu_op=11 throughout.
REQ-037 MULT then DIV back-to-back -> DIV stalled through hilo_we cycle 5, accepted cycle 6, busy cycles 7-14, hilo_we cycle 15.
REQ-038 rst_n=0 at cycle 2 of a DIV -> busy=0 from cycle 3, no hilo_we ever; new MULT accepted normally after reset release.
